// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_data_avail;
    logic [7:0]           tx_data_byte;
    logic                 tx_active;
    logic                 tx_done;
    logic                 busy;
    logic [IDW-1:0]       grant_id;

    modport master (
        input  req_valid, req_data, tx_active, tx_done,
        output req_ready, tx_data_avail, tx_data_byte, busy, grant_id
    );

    modport slave (
        output req_valid, req_data, tx_active, tx_done,
        input  req_ready, tx_data_avail, tx_data_byte, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one 8N1 UART transmitter
// Define UART_TX_TAG_EN to precede every data byte with a tag byte {4'hA, grant index}.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4
) (
    input logic               clk,
    input logic               rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = IDW + 1;

`ifdef UART_TX_TAG_EN
    typedef enum logic [2:0] {ARB, ISSUE, WAIT_ACT, WAIT_DONE, ISSUE_TAG, WAIT_TAG} state_t;
`else
    typedef enum logic [1:0] {ARB, ISSUE, WAIT_ACT, WAIT_DONE} state_t;
`endif

    state_t               state;
    state_t               state_nxt;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       ptr_next;
    logic [IDW-1:0]       grant_r;
    logic [7:0]           byte_r;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [7:0]           req_bytes [NUM_REQ];
    logic                 win_found;
    logic [IDW-1:0]       win_idx;
    logic [CW-1:0]        cand;
`ifdef UART_TX_TAG_EN
    logic [7:0]           hold_r;
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign req_bytes[i]    = bus.req_data[8*i +: 8];
        assign grant_onehot[i] = (grant_r == IDW'(i));
    end

    assign ptr_next         = (grant_r == IDW'(NUM_REQ - 1)) ? '0 : grant_r + IDW'(1);
    assign bus.busy         = (state != ARB);
    assign bus.grant_id     = grant_r;
    assign bus.tx_data_byte = byte_r;

    // Rotating search from the pointer; the modulo wrap handles non power-of-two counts.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = CW'(rr_ptr) + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!win_found && bus.req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        bus.tx_data_avail = 1'b0;
        bus.req_ready     = '0;
        case (state)
            ARB: begin
                if (win_found) begin
`ifdef UART_TX_TAG_EN
                    state_nxt = ISSUE_TAG;
`else
                    state_nxt = ISSUE;
`endif
                end
            end
`ifdef UART_TX_TAG_EN
            ISSUE_TAG: begin
                bus.tx_data_avail = 1'b1;
                bus.req_ready     = grant_onehot;
                state_nxt         = WAIT_TAG;
            end
            WAIT_TAG: begin
                if (bus.tx_done) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.tx_data_avail = 1'b1;
                state_nxt         = WAIT_ACT;
            end
`else
            ISSUE: begin
                bus.tx_data_avail = 1'b1;
                bus.req_ready     = grant_onehot;
                state_nxt         = WAIT_ACT;
            end
`endif
            // A done pulse without a prior active flag still closes the frame.
            WAIT_ACT: begin
                if (bus.tx_done) begin
                    state_nxt = ARB;
                end else if (bus.tx_active) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            grant_r <= '0;
            byte_r  <= 8'h00;
`ifdef UART_TX_TAG_EN
            hold_r  <= 8'h00;
`endif
        end else begin
            case (state)
                ARB: begin
                    if (win_found) begin
                        grant_r <= win_idx;
`ifdef UART_TX_TAG_EN
                        byte_r  <= {4'hA, 4'(win_idx)};
                        hold_r  <= req_bytes[win_idx];
`else
                        byte_r  <= req_bytes[win_idx];
`endif
                    end
                end
`ifdef UART_TX_TAG_EN
                ISSUE_TAG: rr_ptr <= ptr_next;
                WAIT_TAG: begin
                    if (bus.tx_done) begin
                        byte_r <= hold_r;
                    end
                end
`else
                ISSUE: rr_ptr <= ptr_next;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8N1, valid-pulse/active/done handshake) among NUM_REQ byte requesters using round-robin arbitration.
- Accepts one byte at a time from the granted requester and pulses the transmitter's data-available input.
- Waits for the transmitter's done pulse before arbitrating again.
- Sits between the application byte sources and the transmitter instance; clk and rst_n are shared with the transmitter.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16, need not be a power of two.
- IDW, $clog2(NUM_REQ), width of the requester index (derived; do not override).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  bit i high = requester i has a byte pending; held high until its req_ready pulse.
- req_data  input  8*NUM_REQ  byte of requester i on bits [8*i+7:8*i]; held stable while req_valid[i] is high.
- req_ready  output  NUM_REQ  one-cycle pulse on bit i = byte of requester i accepted.
- tx_data_avail  output  1  one-cycle pulse to the transmitter's data-available input.
- tx_data_byte  output  8  byte to the transmitter; held stable from the tx_data_avail pulse until tx_done.
- tx_active  input  1  transmitter busy flag.
- tx_done  input  1  transmitter one-cycle completion pulse.
- busy  output  1  high in every state except ARB.
- grant_id  output  IDW  index of the current or last granted requester.

Behaviour:
- Reset values (asynchronous, while rst_n is low): req_ready=0, tx_data_avail=0, tx_data_byte=8'h00, busy=0, grant_id=0, round-robin pointer=0, state=ARB.
- Reset asserted mid-frame aborts immediately with no completion. The transmitter resets on the same rst_n, so no stale done pulse is expected.
- States: ARB, ISSUE, WAIT_ACT, WAIT_DONE.
- ARB:
  - Search req_valid starting at the pointer, ascending, wrapping from NUM_REQ-1 to 0. The first set bit wins (index g).
  - On a win: register the byte of requester g into tx_data_byte, set grant_id=g, go to ISSUE.
  - If no bit is set: stay in ARB.
- ISSUE (exactly 1 cycle):
  - tx_data_avail=1 and req_ready[g]=1.
  - Pointer becomes g+1, or 0 if g=NUM_REQ-1.
  - Go to WAIT_ACT.
- WAIT_ACT: wait for tx_active=1, then go to WAIT_DONE. If tx_done arrives first, treat it as done and go to ARB.
- WAIT_DONE: on tx_done=1, go to ARB. A new arbitration happens in the following cycle.
- Latency: req_valid seen in ARB at cycle T gives req_ready and tx_data_avail at T+1.
- Minimum spacing between grants: one frame (10*CLKS_PER_BIT cycles of the transmitter) plus 3 cycles.
- req_valid deasserted by a requester before its ready pulse: permitted only while that requester is not granted. Once captured in ARB, the byte is sent regardless.
- Simultaneous requests: exactly one grant per frame. With all bits held high, grants cycle 0,1,..,NUM_REQ-1,0.
- Only one req_ready bit is ever high, and it is never high outside ISSUE.
- tx_data_avail is never asserted unless the state is ARB→ISSUE. The transmitter is therefore idle whenever it is pulsed.

Optional Feature:
- Macro: UART_TX_TAG_EN.
- Defined:
  - Each grant first sends a tag byte {4'hA, 4-bit grant index zero-extended}, then the data byte.
  - Added states ISSUE_TAG and WAIT_TAG, with the same active/done handshake as above.
  - Order: ARB → ISSUE_TAG → WAIT_TAG → ISSUE → WAIT_ACT → WAIT_DONE.
  - req_ready pulses in ISSUE_TAG, and the data byte is held internally.
  - The pointer updates in ISSUE_TAG.
- Undefined: no tag states, behaviour exactly as described above.

Test Plan:
- Reset: hold rst_n low with req_valid=4'b1111 → no req_ready or tx_data_avail. All outputs hold reset values; busy=0.
- Single request: req_valid[2]=1, byte 8'h5A, paired with the transmitter at CLKS_PER_BIT=4 → req_ready[2] and tx_data_avail pulse one cycle after, tx_data_byte=8'h5A, grant_id=2. The serial line shows 0, 01011010 LSB-first, 1. busy stays high until one cycle after tx_done.
- Fairness: req_valid=4'b1111 held, bytes 8'h10..8'h13 → grants in order 0,1,2,3,0. No second grant before the previous tx_done.
- Wrap with gaps: pointer=3 and req_valid=4'b0101 → grant 0, then grant 2, then grant 0.
- Reset mid-frame: assert rst_n during the data bits of a grant to requester 1 → outputs return to reset values at once. After release with req_valid[1] still high, requester 1 is re-granted and its byte resent.
- Tag build (UART_TX_TAG_EN): req_valid[3]=1 with 8'hC3 → the line carries 8'hA3 then 8'hC3. req_ready[3] pulses once; two tx_done pulses occur before busy=0.
